// File: rtl/rd_budget_monitor.sv
// rd_budget_monitor: passive AXI read-path timing monitor with per-slot phase budgets and a sticky first-error record
module rd_budget_monitor #(
    parameter int IdWidth      = 6,
    parameter int NumSlots     = 8,
    parameter int CntWidth     = 10,
    parameter int LenWidth     = 8,
    parameter int PrescalerDiv = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic                ar_valid_i,
    input  logic                ar_ready_i,
    input  logic [IdWidth-1:0]  ar_id_i,
    input  logic [LenWidth-1:0] ar_len_i,
    input  logic                r_valid_i,
    input  logic                r_ready_i,
    input  logic                r_last_i,
    input  logic [IdWidth-1:0]  r_id_i,
    input  logic [CntWidth-1:0] budget_ar_i,
    input  logic [CntWidth-1:0] budget_unit_r_i,
    input  logic [CntWidth-1:0] budget_rhs_i,
    output logic                ar_stall_o,
    output logic                full_o,
    output logic                err_valid_o,
    output logic [1:0]          err_phase_o,
    output logic [IdWidth-1:0]  err_id_o
);
    localparam int BW = CntWidth + LenWidth + 1;
    localparam int PW = PrescalerDiv > 1 ? $clog2(PrescalerDiv) : 1;
    localparam logic [1:0] FREE = 2'd0, ADDR = 2'd1, DATA = 2'd2;

    logic [PW-1:0]       presc_q;
    logic                tick;
    logic [1:0]          st_q [NumSlots];
    logic [1:0]          st_d [NumSlots];
    logic [IdWidth-1:0]  id_q [NumSlots];
    logic [IdWidth-1:0]  id_d [NumSlots];
    logic [BW-1:0]       cnt_q [NumSlots];
    logic [BW-1:0]       cnt_d [NumSlots];
    logic [BW-1:0]       bud_q [NumSlots];
    logic [BW-1:0]       bud_d [NumSlots];
    logic [CntWidth-1:0] rhs_q, rhs_d;
    logic [BW-1:0]       data_budget;
    logic                id_busy, addr_busy, alloc, r_hit, r_beat, rhs_to, unexp;
    logic                addr_to, data_to, new_err;
    logic [IdWidth-1:0]  addr_id, data_id, new_id;
    logic [1:0]          new_phase;

    assign tick = presc_q == PW'(PrescalerDiv - 1);
    // unit*(len+1) written as unit*len+unit so the product never exceeds BW bits
    assign data_budget = BW'(budget_unit_r_i) * BW'(ar_len_i) + BW'(budget_unit_r_i);
    assign r_beat = r_valid_i && r_ready_i;

    always_comb begin
        full_o = 1'b1;
        id_busy = 1'b0;
        addr_busy = 1'b0;
        r_hit = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            full_o = full_o && st_q[i] != FREE;
            id_busy = id_busy || (st_q[i] != FREE && id_q[i] == ar_id_i);
            addr_busy = addr_busy || st_q[i] == ADDR;
            r_hit = r_hit || (st_q[i] == DATA && id_q[i] == r_id_i);
        end
        ar_stall_o = full_o || (ar_valid_i && id_busy);
    end

    assign alloc = ar_valid_i && !addr_busy && !ar_stall_o;

    always_comb begin
        logic hs, tmo, taken;
        st_d = st_q;
        id_d = id_q;
        cnt_d = cnt_q;
        bud_d = bud_q;
        addr_to = 1'b0;
        data_to = 1'b0;
        addr_id = '0;
        data_id = '0;
        hs = 1'b0;
        tmo = 1'b0;
        taken = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            hs = st_q[i] == ADDR ? ar_valid_i && ar_ready_i
                                 : st_q[i] == DATA && r_beat && r_last_i && r_id_i == id_q[i];
            tmo = tick && st_q[i] != FREE && bud_q[i] != '0 && cnt_q[i] + BW'(1) == bud_q[i];
            if (st_q[i] == FREE) begin
                if (alloc && !taken) begin
                    taken = 1'b1;
                    st_d[i] = ar_ready_i ? DATA : ADDR;
                    id_d[i] = ar_id_i;
                    cnt_d[i] = '0;
                    bud_d[i] = ar_ready_i ? data_budget : BW'(budget_ar_i);
                end
            end else if (hs) begin
                // completion is checked before timeout so a same-cycle handshake wins
                st_d[i] = st_q[i] == ADDR ? DATA : FREE;
                cnt_d[i] = '0;
                bud_d[i] = data_budget;
            end else if (tmo) begin
                st_d[i] = FREE;
                if (st_q[i] == ADDR) begin
                    addr_to = 1'b1;
                    addr_id = id_q[i];
                end else if (!data_to) begin
                    data_to = 1'b1;
                    data_id = id_q[i];
                end
            end else begin
                cnt_d[i] = tick ? cnt_q[i] + BW'(1) : cnt_q[i];
            end
        end
    end

    assign rhs_to = tick && r_valid_i && !r_ready_i && budget_rhs_i != '0 &&
                    rhs_q + CntWidth'(1) == budget_rhs_i;
    assign rhs_d = (!r_valid_i || r_ready_i || rhs_to) ? '0 : tick ? rhs_q + CntWidth'(1) : rhs_q;
    assign unexp = r_beat && !r_hit;
    assign new_err = addr_to || data_to || rhs_to || unexp;
    assign new_phase = addr_to ? 2'd0 : data_to ? 2'd1 : rhs_to ? 2'd2 : 2'd3;
    assign new_id = addr_to ? addr_id : data_to ? data_id : r_id_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            rhs_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                st_q[i] <= FREE;
                id_q[i] <= '0;
                cnt_q[i] <= '0;
                bud_q[i] <= '0;
            end
        end else if (!enable_i) begin
            presc_q <= '0;
            rhs_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                st_q[i] <= FREE;
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            rhs_q <= rhs_d;
            st_q <= st_d;
            id_q <= id_d;
            cnt_q <= cnt_d;
            bud_q <= bud_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {err_valid_o, err_phase_o, err_id_o} <= '0;
        end else if (enable_i && new_err && (!err_valid_o || clear_i)) begin
            err_valid_o <= 1'b1;
            err_phase_o <= new_phase;
            err_id_o <= new_id;
        end else if (clear_i) begin
            {err_valid_o, err_phase_o, err_id_o} <= '0;
        end
    end
endmodule

// File: tb/tb_rd_budget_monitor.sv
// tb_rd_budget_monitor: directed stimulus with a queue scoreboard checking latched error records
module tb_rd_budget_monitor;
    typedef struct {
        int ph;
        int id;
        int lo;
        int hi;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, en0 = 1'b0, en1 = 1'b0, clear = 1'b0;
    logic       ar_valid = 1'b0, ar_ready = 1'b0, r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
    logic [5:0] ar_id = '0, r_id = '0;
    logic [7:0] ar_len = '0;
    logic [9:0] b_ar = 10'd3, b_unit = 10'd2, b_rhs0 = 10'd0;
    logic       stall0, full0, ev0, stall1, full1, ev1;
    logic [1:0] ph0, ph1;
    logic [5:0] eid0, eid1;
    int         cyc = 0, checks = 0, errors = 0;
    exp_t       q0[$], q1[$];

    rd_budget_monitor #(.IdWidth(6), .NumSlots(2), .CntWidth(10), .LenWidth(8), .PrescalerDiv(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en0), .clear_i(clear),
        .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last), .r_id_i(r_id),
        .budget_ar_i(b_ar), .budget_unit_r_i(b_unit), .budget_rhs_i(b_rhs0),
        .ar_stall_o(stall0), .full_o(full0), .err_valid_o(ev0), .err_phase_o(ph0), .err_id_o(eid0)
    );

    rd_budget_monitor #(.IdWidth(6), .NumSlots(8), .CntWidth(10), .LenWidth(8), .PrescalerDiv(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .clear_i(clear),
        .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last), .r_id_i(r_id),
        .budget_ar_i(10'd0), .budget_unit_r_i(10'd0), .budget_rhs_i(10'd2),
        .ar_stall_o(stall1), .full_o(full1), .err_valid_o(ev1), .err_phase_o(ph1), .err_id_o(eid1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic r_beat(input logic [5:0] id);
        r_valid = 1'b1;
        r_ready = 1'b1;
        r_last = 1'b1;
        r_id = id;
        step(1);
        r_valid = 1'b0;
        r_ready = 1'b0;
        r_last = 1'b0;
    endtask

    // single-cycle AR with len 3 (budget 8); last beat handshakes at relative tick `beat`
    task automatic burst(input logic [5:0] id, input int beat, input bit err);
        int c;
        c = cyc;
        if (err) q0.push_back('{1, int'(id), c + 9, c + 9});
        ar_valid = 1'b1;
        ar_ready = 1'b1;
        ar_id = id;
        ar_len = 8'd3;
        step(1);
        ar_valid = 1'b0;
        ar_ready = 1'b0;
        step(beat - 1);
        r_beat(id);
        step(2);
    endtask

    initial begin : mon0
        logic pv;
        logic [1:0] pp;
        logic [5:0] pid;
        exp_t e;
        pv = 1'b0;
        pp = '0;
        pid = '0;
        forever begin
            @(negedge clk);
            if (!rst && ev0 && (!pv || ph0 != pp || eid0 != pid)) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut0_spurious_error: got phase=%0d id=%0d at cycle %0d, required none", ph0, eid0, cyc);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_err_phase", int'(ph0), e.ph);
                    chk("dut0_err_id", int'(eid0), e.id);
                    chk_rng("dut0_err_cycle", cyc, e.lo, e.hi);
                end
            end
            pv = !rst && ev0;
            pp = ph0;
            pid = eid0;
        end
    end

    initial begin : mon1
        logic pv;
        logic [1:0] pp;
        logic [5:0] pid;
        exp_t e;
        pv = 1'b0;
        pp = '0;
        pid = '0;
        forever begin
            @(negedge clk);
            if (!rst && ev1 && (!pv || ph1 != pp || eid1 != pid)) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1_spurious_error: got phase=%0d id=%0d at cycle %0d, required none", ph1, eid1, cyc);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_err_phase", int'(ph1), e.ph);
                    chk("dut1_err_id", int'(eid1), e.id);
                    chk_rng("dut1_err_cycle", cyc, e.lo, e.hi);
                end
            end
            pv = !rst && ev1;
            pp = ph1;
            pid = eid1;
        end
    end

    initial begin : stim
        int c;
        exp_t e;
        step(2);
        chk("rst_err_valid0", ev0, 0);
        chk("rst_err_phase0", ph0, 0);
        chk("rst_err_id0", eid0, 0);
        chk("rst_full0", full0, 0);
        chk("rst_stall0", stall0, 0);
        chk("rst_err_valid1", ev1, 0);
        chk("rst_err_phase1", ph1, 0);
        chk("rst_err_id1", eid1, 0);
        chk("rst_full1", full1, 0);
        chk("rst_stall1", stall1, 0);
        rst = 1'b0;
        en0 = 1'b1;
        step(2);

        c = cyc;
        q0.push_back('{0, 5, c + 4, c + 4});
        ar_valid = 1'b1;
        ar_ready = 1'b0;
        ar_id = 6'd5;
        step(3);
        chk("ar_inflight_stall", stall0, 1);
        step(1);
        chk("ar_timeout_slot_freed", stall0, 0);
        ar_valid = 1'b0;
        pulse_clear();
        chk("clear_record", ev0, 0);

        burst(6'd3, 7, 1'b0);
        chk("burst_tick7_no_err", ev0, 0);
        burst(6'd3, 8, 1'b0);
        chk("burst_tick8_no_err", ev0, 0);
        burst(6'd3, 9, 1'b1);
        pulse_clear();

        c = cyc;
        q0.push_back('{3, 9, c + 1, c + 1});
        r_beat(6'd9);
        step(2);
        c = cyc;
        q0.push_back('{0, 7, c + 4, c + 4});
        ar_valid = 1'b1;
        ar_ready = 1'b0;
        ar_id = 6'd7;
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        ar_valid = 1'b0;
        step(1);

        b_unit = 10'd0;
        ar_valid = 1'b1;
        ar_ready = 1'b1;
        ar_id = 6'd1;
        ar_len = 8'd0;
        step(1);
        ar_ready = 1'b0;
        #1;
        chk("dup_id_stall_not_full", stall0, 1);
        chk("one_slot_not_full", full0, 0);
        ar_ready = 1'b1;
        ar_id = 6'd2;
        step(1);
        ar_valid = 1'b0;
        ar_ready = 1'b0;
        #1;
        chk("capacity_full", full0, 1);
        chk("capacity_stall_idle", stall0, 1);
        ar_valid = 1'b1;
        ar_id = 6'd1;
        #1;
        chk("capacity_dup_stall", stall0, 1);
        ar_valid = 1'b0;
        en0 = 1'b0;
        step(1);
        chk("disable_frees_slots", full0, 0);
        chk("disable_keeps_valid", ev0, 1);
        chk("disable_keeps_phase", ph0, 0);
        chk("disable_keeps_id", eid0, 7);
        en0 = 1'b1;
        b_unit = 10'd2;
        pulse_clear();

        c = cyc;
        q0.push_back('{2, 6, c + 3, c + 3});
        b_rhs0 = 10'd3;
        r_valid = 1'b1;
        r_ready = 1'b0;
        r_id = 6'd6;
        step(4);
        r_valid = 1'b0;
        b_rhs0 = 10'd0;
        step(1);

        c = cyc;
        q1.push_back('{2, 4, c + 5, c + 8});
        en1 = 1'b1;
        r_valid = 1'b1;
        r_ready = 1'b0;
        r_id = 6'd4;
        step(10);
        r_valid = 1'b0;
        en1 = 1'b0;
        step(1);

        ar_valid = 1'b1;
        ar_ready = 1'b0;
        ar_id = 6'd4;
        step(1);
        rst = 1'b1;
        #1;
        chk("midreset_full", full0, 0);
        chk("midreset_stall", stall0, 0);
        chk("midreset_err_valid", ev0, 0);
        ar_valid = 1'b0;
        step(2);
        rst = 1'b0;
        step(6);
        chk("after_reset_no_err", ev0, 0);

        while (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            errors++;
            $display("FAIL dut0_missing_error: got none, required phase=%0d id=%0d by cycle %0d", e.ph, e.id, e.hi);
        end
        while (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            errors++;
            $display("FAIL dut1_missing_error: got none, required phase=%0d id=%0d by cycle %0d", e.ph, e.id, e.hi);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
